bp_nonidem_gate: RTL and testbench
==================================

# bp_nonidem_gate

Single-entry request gate directly downstream of the physical-memory-attribute check. Accepts a translated memory request plus its `uncached`/`nonidem` attributes and forwards idempotent requests to the memory interface after one register stage. Holds non-idempotent requests until the core declares them non-speculative, or squashes them on flush. Tracks outstanding uncached requests with a credit counter so I/O ordering and fences are enforced at this point.

## Interface
Parameters:
- `ptag_width_p`, 28: physical tag width.
- `page_offset_width_p`, 12: page offset width.
- `dword_width_p`, 64: store data width.
- `credits_p`, 4: maximum outstanding uncached requests; must be ≥1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  reset; synchronous, active-high.
- `req_v_i`  in  1  upstream request valid.
- `req_ready_and_o`  out  1  gate can accept; ready-and handshake.
- `req_ptag_i`  in  `ptag_width_p`  physical tag.
- `req_offset_i`  in  `page_offset_width_p`  page offset.
- `req_store_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  log2 bytes.
- `req_data_i`  in  `dword_width_p`  store data.
- `req_uncached_i`  in  1  PMA uncached attribute.
- `req_nonidem_i`  in  1  PMA non-idempotent attribute.
- `commit_i`  in  1  held request is now non-speculative.
- `flush_i`  in  1  squash any speculative held request.
- `mem_v_o`  out  1  downstream request valid.
- `mem_ready_and_i`  in  1  downstream accepts.
- `mem_ptag_o`, `mem_offset_o`, `mem_store_o`, `mem_size_o`, `mem_data_o`, `mem_uncached_o`  out  as inputs  registered payload.
- `uncached_resp_i`  in  1  one uncached response returned; returns one credit.
- `empty_o`  out  1  nothing held and zero uncached outstanding; used for fences.

## Operation
- Storage: one payload register, plus a `nonidem` flag and a `committed` flag.
- Credit counter `cnt`, width `$clog2(credits_p+1)`:
  - +1 on a downstream handshake with `mem_uncached_o=1`.
  - −1 on `uncached_resp_i`.
  - Both in the same cycle: unchanged.
  - `uncached_resp_i` with `cnt==0` is illegal; assert in simulation.
- FSM states: READY, WAIT_COMMIT, SEND.
  - READY:
    - `req_ready_and_o = (cnt < credits_p)`. It never depends on request payload.
    - On handshake, latch payload and `nonidem`; clear `committed`.
    - If `req_nonidem_i=1`, go to WAIT_COMMIT; else go to SEND.
  - WAIT_COMMIT:
    - `flush_i` returns to READY and drops the entry. Flush wins over a simultaneous `commit_i`.
    - `commit_i` sets `committed` and goes to SEND.
  - SEND:
    - `mem_v_o = 1` for an idempotent entry, or for a non-idempotent entry only when `cnt==0`. This serializes I/O behind all earlier uncached responses.
    - Handshake returns to READY.
    - `flush_i` with an idempotent entry drops it and returns to READY; `mem_v_o` is deasserted that cycle.
    - `flush_i` with a committed entry is ignored; the entry must still issue.
- Payload outputs are driven from the register in every state. They are don't-care when `mem_v_o=0`.
- `empty_o = (state==READY) & (cnt==0)`.
- Reset, including mid-operation: state READY, `cnt=0`, flags cleared, held entry discarded. Reset outputs: `mem_v_o=0`, `req_ready_and_o=0` during reset and 1 the cycle after, `empty_o=1` after reset.

## Timing
- Idempotent request accepted at cycle N: `mem_v_o=1` at N+1, held until `mem_ready_and_i`.
- Non-idempotent request accepted at N: earliest `commit_i` is N+1. `commit_i` at M gives `mem_v_o` at M+1 if `cnt==0`.
- A `commit_i` in the same cycle as acceptance is ignored.
- No new acceptance in the cycle the downstream handshake completes; the next acceptance is one cycle later. Throughput is one request per 2 cycles.
- A credit returned at cycle K is usable for acceptance at K+1.
- No combinational path from `req_*` to `mem_*`.

## Test plan
- Cached load, `mem_ready_and_i=1`: `req_v_i` at cycle 1 → `mem_v_o=1` with identical payload at cycle 2, `req_ready_and_o=1` at cycle 3.
- Uncached idempotent stores, `credits_p=4`, no responses: after 4 issued, `req_ready_and_o=0`. One `uncached_resp_i` → `req_ready_and_o=1` next cycle.
- Non-idempotent load, `commit_i` at cycle 5 → `mem_v_o` first high at cycle 6. With `cnt=2` at commit, `mem_v_o` stays low until the cycle after the second response.
- Non-idempotent entry with `flush_i` and `commit_i` asserted together in WAIT_COMMIT → no `mem_v_o`, READY next cycle, `cnt` unchanged.
- Committed entry in SEND with `mem_ready_and_i=0` and `flush_i=1` → `mem_v_o` stays high, entry issues once ready rises. Idempotent entry in the same situation → dropped.
- `reset_i` asserted while in SEND with `cnt=3` → cycle after reset: `mem_v_o=0`, `empty_o=1`, `req_ready_and_o=1`.

Source files
------------

// File: rtl/bp_nonidem_gate.sv
// bp_nonidem_gate: single-entry request gate after the PMA check.
// Idempotent requests issue one cycle after acceptance; non-idempotent
// requests wait for commit_i (or are squashed by flush_i). A credit counter
// tracks outstanding uncached requests; non-idempotent issue waits for zero.
// Ports: req_* upstream (ready-and), mem_* downstream (ready-and),
// commit_i/flush_i from the core, uncached_resp_i returns one credit,
// empty_o reports nothing held and nothing uncached outstanding.
module bp_nonidem_gate #(
  parameter int unsigned ptag_width_p        = 28,
  parameter int unsigned page_offset_width_p = 12,
  parameter int unsigned dword_width_p       = 64,
  parameter int unsigned credits_p           = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic                           req_v_i,
  output logic                           req_ready_and_o,
  input  logic [ptag_width_p-1:0]        req_ptag_i,
  input  logic [page_offset_width_p-1:0] req_offset_i,
  input  logic                           req_store_i,
  input  logic [1:0]                     req_size_i,
  input  logic [dword_width_p-1:0]       req_data_i,
  input  logic                           req_uncached_i,
  input  logic                           req_nonidem_i,

  input  logic                           commit_i,
  input  logic                           flush_i,

  output logic                           mem_v_o,
  input  logic                           mem_ready_and_i,
  output logic [ptag_width_p-1:0]        mem_ptag_o,
  output logic [page_offset_width_p-1:0] mem_offset_o,
  output logic                           mem_store_o,
  output logic [1:0]                     mem_size_o,
  output logic [dword_width_p-1:0]       mem_data_o,
  output logic                           mem_uncached_o,

  input  logic                           uncached_resp_i,
  output logic                           empty_o
);

  localparam int unsigned CntW = $clog2(credits_p + 1);
  localparam logic [CntW-1:0] CreditsMax = CntW'(credits_p);

  typedef enum logic [1:0] {
    StReady,
    StWaitCommit,
    StSend
  } state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           nonidem_q, nonidem_d;
  logic                           committed_q, committed_d;

  logic [ptag_width_p-1:0]        ptag_q;
  logic [page_offset_width_p-1:0] offset_q;
  logic                           store_q;
  logic [1:0]                     size_q;
  logic [dword_width_p-1:0]       data_q;
  logic                           uncached_q;

  logic                           req_hs;
  logic                           mem_hs;

  // Outputs are gated by reset so a mid-operation reset silences the
  // interface in the reset cycle itself.
  always_comb begin
    req_ready_and_o = 1'b0;
    mem_v_o         = 1'b0;
    if (!reset_i) begin
      req_ready_and_o = (state_q == StReady) && (cnt_q < CreditsMax);
      if (state_q == StSend) begin
        // I/O waits for all earlier uncached responses; a flushed
        // idempotent entry is withdrawn in the flush cycle.
        mem_v_o = nonidem_q ? (cnt_q == '0) : !flush_i;
      end
    end
  end

  assign req_hs  = req_v_i && req_ready_and_o;
  assign mem_hs  = mem_v_o && mem_ready_and_i;
  assign empty_o = (state_q == StReady) && (cnt_q == '0);

  assign mem_ptag_o     = ptag_q;
  assign mem_offset_o   = offset_q;
  assign mem_store_o    = store_q;
  assign mem_size_o     = size_q;
  assign mem_data_o     = data_q;
  assign mem_uncached_o = uncached_q;

  always_comb begin
    state_d     = state_q;
    nonidem_d   = nonidem_q;
    committed_d = committed_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StReady: begin
        if (req_hs) begin
          nonidem_d   = req_nonidem_i;
          committed_d = 1'b0;
          state_d     = req_nonidem_i ? StWaitCommit : StSend;
        end
      end
      StWaitCommit: begin
        if (flush_i) begin
          state_d = StReady;
        end else if (commit_i) begin
          committed_d = 1'b1;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (mem_hs) begin
          state_d = StReady;
        end else if (flush_i && !committed_q) begin
          state_d = StReady;
        end
      end
      default: state_d = StReady;
    endcase

    unique case ({mem_hs && uncached_q, uncached_resp_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StReady;
      cnt_q       <= '0;
      nonidem_q   <= 1'b0;
      committed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nonidem_q   <= nonidem_d;
      committed_q <= committed_d;
    end
  end

  // Payload is don't-care while nothing is held, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      ptag_q     <= req_ptag_i;
      offset_q   <= req_offset_i;
      store_q    <= req_store_i;
      size_q     <= req_size_i;
      data_q     <= req_data_i;
      uncached_q <= req_uncached_i;
    end
  end

  a_resp_needs_credit : assert property (
    @(posedge clk_i) disable iff (reset_i) !(uncached_resp_i && (cnt_q == '0))
  );

endmodule

// File: tb/tb_bp_nonidem_gate.sv
module tb_bp_nonidem_gate;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_v_i;
  logic        req_ready_and_o;
  logic [27:0] req_ptag_i;
  logic [11:0] req_offset_i;
  logic        req_store_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_data_i;
  logic        req_uncached_i;
  logic        req_nonidem_i;
  logic        commit_i;
  logic        flush_i;
  logic        mem_v_o;
  logic        mem_ready_and_i;
  logic [27:0] mem_ptag_o;
  logic [11:0] mem_offset_o;
  logic        mem_store_o;
  logic [1:0]  mem_size_o;
  logic [63:0] mem_data_o;
  logic        mem_uncached_o;
  logic        uncached_resp_i;
  logic        empty_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  bp_nonidem_gate #(
    .ptag_width_p(28),
    .page_offset_width_p(12),
    .dword_width_p(64),
    .credits_p(4)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .req_v_i(req_v_i),
    .req_ready_and_o(req_ready_and_o),
    .req_ptag_i(req_ptag_i),
    .req_offset_i(req_offset_i),
    .req_store_i(req_store_i),
    .req_size_i(req_size_i),
    .req_data_i(req_data_i),
    .req_uncached_i(req_uncached_i),
    .req_nonidem_i(req_nonidem_i),
    .commit_i(commit_i),
    .flush_i(flush_i),
    .mem_v_o(mem_v_o),
    .mem_ready_and_i(mem_ready_and_i),
    .mem_ptag_o(mem_ptag_o),
    .mem_offset_o(mem_offset_o),
    .mem_store_o(mem_store_o),
    .mem_size_o(mem_size_o),
    .mem_data_o(mem_data_o),
    .mem_uncached_o(mem_uncached_o),
    .uncached_resp_i(uncached_resp_i),
    .empty_o(empty_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    req_v_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0;
    mem_ready_and_i = 1'b0; uncached_resp_i = 1'b0;
  endtask

  task automatic set_req(input logic [27:0] ptag, input logic [11:0] off, input logic st,
                         input logic [1:0] sz, input logic [63:0] dat, input logic unc,
                         input logic ni);
    req_ptag_i = ptag; req_offset_i = off; req_store_i = st; req_size_i = sz;
    req_data_i = dat; req_uncached_i = unc; req_nonidem_i = ni;
  endtask

  // Pure stimulus: accept one uncached idempotent store and issue it.
  task automatic issue_uncached();
    set_req(28'h0000100, 12'h010, 1'b1, 2'd3, 64'h55, 1'b1, 1'b0);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0; mem_ready_and_i = 1'b1;
    tick();
    mem_ready_and_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    idle();
    set_req('0, '0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    tick(); settle();
    checks++; if (req_ready_and_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", req_ready_and_o); end
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL rst_memv got=%b exp=0", mem_v_o); end
    tick();
    reset_i = 1'b0;
    settle();
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b exp=1", req_ready_and_o); end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty_o); end
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL rst_memv_after got=%b exp=0", mem_v_o); end
  endtask

  task automatic test_cached_load();
    set_req(28'hABCDE12, 12'h345, 1'b0, 2'd3, 64'h1122334455667788, 1'b0, 1'b0);
    req_v_i = 1'b1; mem_ready_and_i = 1'b1;
    settle();
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL cl_ready got=%b exp=1", req_ready_and_o); end
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL cl_memv_same got=%b exp=0", mem_v_o); end
    tick();
    req_v_i = 1'b0;
    set_req('0, '0, 1'b1, 2'd0, '0, 1'b1, 1'b0);
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL cl_memv got=%b exp=1", mem_v_o); end
    checks++; if (mem_ptag_o !== 28'hABCDE12) begin failures++; $display("FAIL cl_ptag got=%h exp=abcde12", mem_ptag_o); end
    checks++; if (mem_offset_o !== 12'h345) begin failures++; $display("FAIL cl_offset got=%h exp=345", mem_offset_o); end
    checks++; if (mem_data_o !== 64'h1122334455667788) begin failures++; $display("FAIL cl_data got=%h exp=1122334455667788", mem_data_o); end
    checks++; if ({mem_store_o, mem_size_o, mem_uncached_o} !== 4'b0110) begin failures++; $display("FAIL cl_attr got=%b exp=0110", {mem_store_o, mem_size_o, mem_uncached_o}); end
    checks++; if (req_ready_and_o !== 1'b0) begin failures++; $display("FAIL cl_ready_busy got=%b exp=0", req_ready_and_o); end
    tick();
    mem_ready_and_i = 1'b0;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL cl_memv_done got=%b exp=0", mem_v_o); end
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL cl_ready_again got=%b exp=1", req_ready_and_o); end
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL cl_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_uncached_credits();
    for (int i = 0; i < 4; i++) begin
      set_req(28'h0000200, 12'h020, 1'b1, 2'd3, 64'(i), 1'b1, 1'b0);
      req_v_i = 1'b1;
      settle();
      checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL uc_ready_%0d got=%b exp=1", i, req_ready_and_o); end
      tick();
      req_v_i = 1'b0; mem_ready_and_i = 1'b1;
      settle();
      checks++; if ({mem_v_o, mem_uncached_o} !== 2'b11) begin failures++; $display("FAIL uc_issue_%0d got=%b exp=11", i, {mem_v_o, mem_uncached_o}); end
      tick();
      mem_ready_and_i = 1'b0;
    end
    settle();
    checks++; if (req_ready_and_o !== 1'b0) begin failures++; $display("FAIL uc_full got=%b exp=0", req_ready_and_o); end
    checks++; if (empty_o !== 1'b0) begin failures++; $display("FAIL uc_full_empty got=%b exp=0", empty_o); end
    uncached_resp_i = 1'b1;
    settle();
    checks++; if (req_ready_and_o !== 1'b0) begin failures++; $display("FAIL uc_resp_same got=%b exp=0", req_ready_and_o); end
    tick();
    uncached_resp_i = 1'b0;
    settle();
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL uc_resp_next got=%b exp=1", req_ready_and_o); end
    // Issue with a simultaneous response: count must stay at 3.
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0; mem_ready_and_i = 1'b1; uncached_resp_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL uc_both_memv got=%b exp=1", mem_v_o); end
    tick();
    mem_ready_and_i = 1'b0; uncached_resp_i = 1'b0;
    settle();
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL uc_both_ready got=%b exp=1", req_ready_and_o); end
    uncached_resp_i = 1'b1;
    tick(); tick();
    uncached_resp_i = 1'b0;
    settle();
    checks++; if (empty_o !== 1'b0) begin failures++; $display("FAIL uc_drain2 got=%b exp=0", empty_o); end
    uncached_resp_i = 1'b1;
    tick();
    uncached_resp_i = 1'b0;
    settle();
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL uc_drain3 got=%b exp=1", empty_o); end
  endtask

  task automatic test_nonidem_commit();
    set_req(28'h0F00D00, 12'h7A8, 1'b0, 2'd2, 64'hDEAD, 1'b1, 1'b1);
    req_v_i = 1'b1; commit_i = 1'b1;
    settle();
    checks++; if (req_ready_and_o !== 1'b1) begin failures++; $display("FAIL ni_ready got=%b exp=1", req_ready_and_o); end
    tick();
    req_v_i = 1'b0; commit_i = 1'b0;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL ni_wait1 got=%b exp=0", mem_v_o); end
    tick(); settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL ni_wait2 got=%b exp=0", mem_v_o); end
    checks++; if (empty_o !== 1'b0) begin failures++; $display("FAIL ni_wait_empty got=%b exp=0", empty_o); end
    commit_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL ni_commit_same got=%b exp=0", mem_v_o); end
    tick();
    commit_i = 1'b0; flush_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL ni_commit_next got=%b exp=1", mem_v_o); end
    checks++; if ({mem_ptag_o, mem_offset_o} !== {28'h0F00D00, 12'h7A8}) begin failures++; $display("FAIL ni_payload got=%h exp=%h", {mem_ptag_o, mem_offset_o}, {28'h0F00D00, 12'h7A8}); end
    tick();
    flush_i = 1'b0; mem_ready_and_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL ni_flush_ignored got=%b exp=1", mem_v_o); end
    tick();
    mem_ready_and_i = 1'b0;
    settle();
    checks++; if ({req_ready_and_o, empty_o} !== 2'b10) begin failures++; $display("FAIL ni_issued got=%b exp=10", {req_ready_and_o, empty_o}); end
    uncached_resp_i = 1'b1;
    tick();
    uncached_resp_i = 1'b0;
    // Commit with two uncached requests outstanding.
    issue_uncached();
    issue_uncached();
    set_req(28'h0BEEF00, 12'h004, 1'b0, 2'd2, 64'h0, 1'b1, 1'b1);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0; commit_i = 1'b1;
    tick();
    commit_i = 1'b0; mem_ready_and_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL ni_cnt2 got=%b exp=0", mem_v_o); end
    uncached_resp_i = 1'b1;
    tick(); settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL ni_cnt1 got=%b exp=0", mem_v_o); end
    tick();
    uncached_resp_i = 1'b0;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL ni_cnt0 got=%b exp=1", mem_v_o); end
    tick();
    mem_ready_and_i = 1'b0; uncached_resp_i = 1'b1;
    tick();
    uncached_resp_i = 1'b0;
    settle();
    checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL ni_drained got=%b exp=1", empty_o); end
  endtask

  task automatic test_flush_commit();
    set_req(28'h0000300, 12'h030, 1'b1, 2'd1, 64'h9, 1'b1, 1'b1);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0; flush_i = 1'b1; commit_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL fc_memv got=%b exp=0", mem_v_o); end
    tick();
    flush_i = 1'b0; commit_i = 1'b0;
    settle();
    checks++; if ({mem_v_o, req_ready_and_o, empty_o} !== 3'b011) begin failures++; $display("FAIL fc_dropped got=%b exp=011", {mem_v_o, req_ready_and_o, empty_o}); end
  endtask

  task automatic test_flush_idem();
    set_req(28'h0000400, 12'h040, 1'b0, 2'd0, 64'h1, 1'b0, 1'b0);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL fi_memv got=%b exp=1", mem_v_o); end
    flush_i = 1'b1;
    settle();
    checks++; if (mem_v_o !== 1'b0) begin failures++; $display("FAIL fi_flush_memv got=%b exp=0", mem_v_o); end
    tick();
    flush_i = 1'b0;
    settle();
    checks++; if ({mem_v_o, req_ready_and_o, empty_o} !== 3'b011) begin failures++; $display("FAIL fi_dropped got=%b exp=011", {mem_v_o, req_ready_and_o, empty_o}); end
  endtask

  task automatic test_reset_mid();
    issue_uncached();
    issue_uncached();
    issue_uncached();
    set_req(28'h0000500, 12'h050, 1'b0, 2'd3, 64'h2, 1'b0, 1'b0);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
    settle();
    checks++; if (mem_v_o !== 1'b1) begin failures++; $display("FAIL rm_send got=%b exp=1", mem_v_o); end
    reset_i = 1'b1;
    settle();
    checks++; if ({mem_v_o, req_ready_and_o} !== 2'b00) begin failures++; $display("FAIL rm_during got=%b exp=00", {mem_v_o, req_ready_and_o}); end
    tick();
    reset_i = 1'b0;
    settle();
    checks++; if ({mem_v_o, empty_o, req_ready_and_o} !== 3'b011) begin failures++; $display("FAIL rm_after got=%b exp=011", {mem_v_o, empty_o, req_ready_and_o}); end
  endtask

  task automatic test_back_to_back();
    int acc;
    int hs;
    acc = 0; hs = 0;
    set_req(28'h0000600, 12'h060, 1'b0, 2'd3, 64'h3, 1'b0, 1'b0);
    req_v_i = 1'b1; mem_ready_and_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (req_v_i && req_ready_and_o) acc++;
      if (mem_v_o && mem_ready_and_i) hs++;
      tick();
    end
    req_v_i = 1'b0; mem_ready_and_i = 1'b0;
    checks++; if (acc !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc); end
    checks++; if (hs !== 3) begin failures++; $display("FAIL b2b_issues got=%0d exp=3", hs); end
  endtask

  initial begin
    test_reset();
    test_cached_load();
    test_uncached_credits();
    test_nonidem_commit();
    test_flush_commit();
    test_flush_idem();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
